// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execute-side reader.
// Instruction layout, MSB first: opcode[67:64], op_a[63:32], op_b[31:0].
package instr_register_pkg;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, FINISH} exec_state_t;

  function automatic result_t sext(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational execute unit: one instruction_t in, signed 64-bit result and
// error flag out. Shared with the scoreboard's reference model.
module instr_alu
  import instr_register_pkg::*;
(
  input  logic [67:0] instr_word,
  output logic [63:0] res,
  output logic        err
);

  instruction_t ins;
  result_t      a, b, r;

  always_comb begin
    ins = instruction_t'(instr_word);
    a   = sext(ins.op_a);
    b   = sext(ins.op_b);
    r   = '0;
    err = 1'b0;
    case (ins.opc)
      ZERO:  r = '0;
      PASSA: r = a;
      PASSB: r = b;
      ADD:   r = a + b;
      SUB:   r = a - b;
      MULT:  r = a * b;
      // Operands are already 64-bit, so -2^31 / -1 needs no special path.
      DIV:   if (b == '0) err = 1'b1; else r = a / b;
      MOD:   if (b == '0) err = 1'b1; else r = a % b;
      default: err = 1'b1;
    endcase
    res = r;
  end

endmodule

// File: rtl/instr_exec_reader.sv
// Walks COUNT entries of the instruction register, executes each one and
// streams the results out. Optional err_count port: INSTR_EXEC_ERRCNT_EN.
module instr_exec_reader
  import instr_register_pkg::*;
#(
  parameter int RESULT_W = 64,
  parameter int COUNT_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4:0]          base_addr,
  input  logic [COUNT_W-1:0]  count,
  output logic [4:0]          read_pointer,
  input  logic [67:0]         instruction_word,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [RESULT_W-1:0] result,
  output logic [3:0]          result_opc,
  output logic [4:0]          result_addr,
  output logic                result_err,
  output logic                done
`ifdef INSTR_EXEC_ERRCNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  exec_state_t         state_q, state_d;
  address_t            ptr_q, ptr_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic [67:0]         instr_q, instr_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [3:0]          opc_q, opc_d;
  address_t            addr_q, addr_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic [63:0] alu_res;
  logic        alu_err;
  logic        hs;

  instr_alu u_alu (
    .instr_word (instr_q),
    .res        (alu_res),
    .err        (alu_err)
  );

  assign hs = valid_q & result_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    instr_d  = instr_q;
    result_d = result_q;
    opc_d    = opc_q;
    addr_d   = addr_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (start) begin
        if (count != '0) begin
          ptr_d   = base_addr;
          rem_d   = count;
          state_d = FETCH;
        end else begin
          state_d = FINISH;
        end
      end
      FETCH: begin
        instr_d = instruction_word;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_res[RESULT_W-1:0];
        opc_d    = instr_q[67:64];
        addr_d   = ptr_q;
        err_d    = alu_err;
        state_d  = OUT;
      end
      OUT: if (hs) begin
        rem_d = rem_q - COUNT_W'(1);
        if (rem_q == COUNT_W'(1)) begin
          state_d = FINISH;
        end else begin
          ptr_d   = ptr_q + 5'd1;
          state_d = FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered decodes of the next state.
    busy_d  = (state_d == FETCH) || (state_d == EXEC) || (state_d == OUT);
    valid_d = (state_d == OUT);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      instr_q  <= '0;
      result_q <= '0;
      opc_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      opc_q    <= opc_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

`ifdef INSTR_EXEC_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (state_q == IDLE && start)
      errcnt_d = '0;
    else if (hs && err_q && errcnt_q != 8'hFF)
      errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) errcnt_q <= '0;
    else       errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`endif

  assign read_pointer = ptr_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign result_opc   = opc_q;
  assign result_addr  = addr_q;
  assign result_err   = err_q;
  assign done         = done_q;

endmodule
